pmod_host_if: RTL and testbench
===============================

Name: pmod_host_if

Overview:
- Host-side (Microblaze/AXI) end of the Picoblaze register interface for the ECE 544 PmodCLP/PmodENC peripheral.
- Drives the lcd_cmd, lcd_data and rotary_ctl registers, and consumes lcd_status, rotary_status and rotary_count_hi/lo.
- Buffers LCD commands in a small FIFO and issues them using a 4-phase handshake against the lcd_status busy bit.
- Returns a tear-free 16-bit rotary count snapshot to the host.

Parameters:
- FIFO_DEPTH, 4: LCD command FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 1000000: maximum cycles spent in any wait state before abort.
- TOUT_W, 20: timeout counter width; TIMEOUT_CYCLES must be less than 2^TOUT_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- cmd_wr  in  1  push {cmd_code, cmd_data} into FIFO
- cmd_code  in  7  LCD command code
- cmd_data  in  8  LCD data byte accompanying the command
- cmd_full  out  1  FIFO full
- lcd_idle  out  1  FIFO empty and FSM in IDLE
- err_clr  in  1  clears both sticky error flags
- timeout_err  out  1  sticky: a handshake timed out
- overflow_err  out  1  sticky: push attempted while full
- rot_ctl_wr  in  1  load rotary_ctl from rot_ctl_din
- rot_ctl_din  in  8  new rotary control value
- lcd_status  in  8  from Picoblaze; bit7 = busy
- rotary_status  in  8  from Picoblaze; bit0 = count update in progress
- rotary_count_lo  in  8  count bits[7:0]
- rotary_count_hi  in  8  count bits[15:8]
- lcd_cmd  out  8  bit7 = GO, bits[6:0] = code
- lcd_data  out  8  LCD data register
- rotary_ctl  out  8  rotary control register
- rot_count  out  16  last coherent count
- rot_count_upd  out  1  one-cycle pulse when rot_count changes

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset values (reset_n low at a clk edge): lcd_cmd=0x00, lcd_data=0x00, rotary_ctl=0x00, rot_count=0x0000, rot_count_upd=0, both error flags=0, FIFO empty, FSM=INIT.
- Reset mid-handshake aborts immediately; GO drops and queued commands are lost.
- FIFO:
  - Push when cmd_wr=1 and not full.
  - cmd_wr while full: entry dropped, overflow_err set. A same-cycle pop does not rescue the push.
  - Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
  - Pop occurs on the IDLE->ISSUE transition.
- FSM states:
  - INIT: wait for lcd_status[7]=0 (Picoblaze resets this bit to 1). Then go to IDLE.
  - IDLE: if FIFO is non-empty, pop and go to ISSUE.
  - ISSUE: register lcd_data=data and lcd_cmd={1,code}, then go to WAIT_ACK.
  - WAIT_ACK: wait for lcd_status[7]=1.
  - RELEASE: lcd_cmd[7]<=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for lcd_status[7]=0, then go to IDLE.
  - lcd_data holds its value until the next ISSUE.
- Latency: a push at edge N into an idle, empty block makes GO visible on lcd_cmd after edge N+2. Back-to-back commands need at least 1 IDLE cycle between WAIT_DONE and the next ISSUE.
- Timeout:
  - The counter resets on every state entry and counts in INIT, WAIT_ACK and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1: set timeout_err, clear lcd_cmd[7], go to IDLE. The current command is dropped.
  - If INIT times out, the FSM proceeds to IDLE anyway.
- err_clr: clears both flags. A same-cycle set event wins over err_clr.
- rotary_ctl: loaded on rot_ctl_wr and held otherwise; independent of the FSM.
- Rotary snapshot:
  - Each cycle, register cand={hi,lo}.
  - If rotary_status[0]=0 and {hi,lo}==cand for 2 consecutive cycles (stable 3 samples) and the value differs from rot_count: load rot_count and pulse rot_count_upd on the same edge.
  - Any sample with rotary_status[0]=1 restarts the stability count.
  - Wrap 0xFFFF->0x0000 is an ordinary value change.

Decomposition:
- Shared package pmod_if_pkg: FSM state enum; LCD_BUSY_BIT=7; LCD_GO_BIT=7; ROT_UPD_BIT=0; reset constants.
- Sub-module sync_fifo (WIDTH=15, DEPTH=FIFO_DEPTH) for the command buffer.
- FSM, timeout counter and snapshot logic live in pmod_host_if.

Test Plan:
- Reset with lcd_status=0x80, release busy after 10 cycles, push code 0x01/data 0x41 -> no GO before busy clears; lcd_cmd=0x81 and lcd_data=0x41 then; after responder ack/done, lcd_idle=1.
- Push 5 commands with DEPTH=4 and the responder stalled -> cmd_full after 4 pushes, overflow_err=1 on the 5th; the 4 commands issue in order, 5th never appears.
- Responder never asserts busy, TIMEOUT_CYCLES=50 -> timeout_err=1 and lcd_cmd[7]=0 within 50 cycles of GO; next queued command issues; err_clr returns timeout_err to 0.
- Count goes 0x00FF->0x0100 with lo written 3 cycles before hi and rotary_status[0]=1 during the update -> rot_count never shows 0x0000 or 0x01FF; ends at 0x0100 with exactly one rot_count_upd pulse.
- reset_n low for 1 cycle during WAIT_ACK -> all outputs at reset values next cycle, FIFO empty, FSM in INIT.
- rot_ctl_wr with 0x5A during an active handshake -> rotary_ctl=0x5A next cycle; LCD sequence unaffected.

Source files
------------

// File: rtl/pmod_if_pkg.sv
// Shared types and constants for the host side of the Picoblaze PmodCLP/PmodENC register interface.
package pmod_if_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RELEASE,
    ST_WAIT_DONE
  } lcd_state_e;

  localparam int unsigned LCD_BUSY_BIT = 7;
  localparam int unsigned LCD_GO_BIT   = 7;
  localparam int unsigned ROT_UPD_BIT  = 0;

  localparam int unsigned CMD_CODE_W = 7;
  localparam int unsigned CMD_DATA_W = 8;
  localparam int unsigned CMD_W      = CMD_CODE_W + CMD_DATA_W;

  typedef struct packed {
    logic [CMD_CODE_W-1:0] code;
    logic [CMD_DATA_W-1:0] data;
  } lcd_entry_t;

  localparam logic [7:0]  LCD_CMD_RST   = '0;
  localparam logic [7:0]  LCD_DATA_RST  = '0;
  localparam logic [7:0]  ROT_CTL_RST   = '0;
  localparam logic [15:0] ROT_COUNT_RST = '0;

  // Command register image with GO raised.
  function automatic logic [7:0] go_word(input logic [CMD_CODE_W-1:0] code);
    return {1'b1, code};
  endfunction

endpackage

// File: rtl/pmod_host_if_fifo.sv
// Synchronous show-ahead FIFO; extra pointer MSB separates full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push while full is refused even if a pop happens on the same edge.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pmod_host_if.sv
// Host end of the Picoblaze LCD/rotary register interface: queued LCD commands issued
// by a GO/busy 4-phase handshake with timeout, plus a tear-free rotary count snapshot.
module pmod_host_if
  import pmod_if_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TOUT_W         = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_wr,
  input  logic [6:0]  cmd_code,
  input  logic [7:0]  cmd_data,
  output logic        cmd_full,
  output logic        lcd_idle,
  input  logic        err_clr,
  output logic        timeout_err,
  output logic        overflow_err,
  input  logic        rot_ctl_wr,
  input  logic [7:0]  rot_ctl_din,
  input  logic [7:0]  lcd_status,
  input  logic [7:0]  rotary_status,
  input  logic [7:0]  rotary_count_lo,
  input  logic [7:0]  rotary_count_hi,
  output logic [7:0]  lcd_cmd,
  output logic [7:0]  lcd_data,
  output logic [7:0]  rotary_ctl,
  output logic [15:0] rot_count,
  output logic        rot_count_upd
);

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);

  lcd_state_e        state_q, state_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  lcd_entry_t        pend_q, pend_d;
  lcd_entry_t        fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [7:0]        lcd_cmd_q, lcd_cmd_d;
  logic [7:0]        lcd_data_q, lcd_data_d;
  logic [7:0]        rot_ctl_q, rot_ctl_d;
  logic              tout_err_q, tout_err_d;
  logic              ovf_err_q, ovf_err_d;
  logic              tout_evt, ovf_evt;
  logic              busy, tout_hit;

  logic [15:0]       rot_raw;
  logic [15:0]       cand_q;
  logic [1:0]        run_q, run_d;
  logic [15:0]       rot_count_q, rot_count_d;
  logic              rot_upd_q, rot_upd_d;
  logic              rot_in_upd, rot_match, rot_load;

  // Only the handshake and update-in-progress bits carry meaning here.
  logic              unused_status_bits;
  assign unused_status_bits = ^{lcd_status[6:0], rotary_status[7:1]};

  assign busy     = lcd_status[LCD_BUSY_BIT];
  assign tout_hit = (tout_q == TOUT_LAST);

  sync_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push_i (cmd_wr),
    .pop_i  (fifo_pop),
    .wdata_i({cmd_code, cmd_data}),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next-state: handshake progress wins over a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:      if (!busy || tout_hit) state_d = ST_IDLE;
      ST_IDLE:      if (!fifo_empty)       state_d = ST_ISSUE;
      ST_ISSUE:                            state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (busy)              state_d = ST_RELEASE;
                    else if (tout_hit)     state_d = ST_IDLE;
      ST_RELEASE:                          state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!busy || tout_hit) state_d = ST_IDLE;
      default:                             state_d = ST_INIT;
    endcase
  end

  // Outputs per state: pop into the pending slot, drive GO, drop GO on release or timeout.
  always_comb begin
    fifo_pop   = 1'b0;
    tout_evt   = 1'b0;
    pend_d     = pend_q;
    lcd_cmd_d  = lcd_cmd_q;
    lcd_data_d = lcd_data_q;
    unique case (state_q)
      ST_INIT: tout_evt = busy && tout_hit;
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pend_d   = fifo_rdata;
        end
      end
      ST_ISSUE: begin
        lcd_cmd_d  = go_word(pend_q.code);
        lcd_data_d = pend_q.data;
      end
      ST_WAIT_ACK: begin
        if (!busy && tout_hit) begin
          tout_evt              = 1'b1;
          lcd_cmd_d[LCD_GO_BIT] = 1'b0;
        end
      end
      ST_RELEASE: lcd_cmd_d[LCD_GO_BIT] = 1'b0;
      ST_WAIT_DONE: tout_evt = busy && tout_hit;
      default: ;
    endcase
  end

  // Wait-state timer: restarts on every state change, runs only while waiting on busy.
  always_comb begin
    tout_d = '0;
    if ((state_d == state_q) &&
        (state_q inside {ST_INIT, ST_WAIT_ACK, ST_WAIT_DONE}))
      tout_d = tout_q + 1'b1;
  end

  // Sticky errors (set beats clear) and the free-standing rotary control register.
  always_comb begin
    ovf_evt    = cmd_wr && fifo_full;
    tout_err_d = tout_evt ? 1'b1 : (err_clr ? 1'b0 : tout_err_q);
    ovf_err_d  = ovf_evt  ? 1'b1 : (err_clr ? 1'b0 : ovf_err_q);
    rot_ctl_d  = rot_ctl_wr ? rot_ctl_din : rot_ctl_q;
  end

  // Rotary snapshot: accept a value once three consecutive idle samples agree.
  always_comb begin
    rot_raw    = {rotary_count_hi, rotary_count_lo};
    rot_in_upd = rotary_status[ROT_UPD_BIT];
    rot_match  = (rot_raw == cand_q);
    if (rot_in_upd)                     run_d = 2'd0;
    else if (rot_match && run_q != 2'd0) run_d = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
    else                                run_d = 2'd1;
    rot_load    = !rot_in_upd && rot_match && (run_q >= 2'd2) && (rot_raw != rot_count_q);
    rot_count_d = rot_load ? rot_raw : rot_count_q;
    rot_upd_d   = rot_load;
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tout_q      <= '0;
      pend_q      <= '0;
      lcd_cmd_q   <= LCD_CMD_RST;
      lcd_data_q  <= LCD_DATA_RST;
      rot_ctl_q   <= ROT_CTL_RST;
      tout_err_q  <= 1'b0;
      ovf_err_q   <= 1'b0;
      cand_q      <= '0;
      run_q       <= '0;
      rot_count_q <= ROT_COUNT_RST;
      rot_upd_q   <= 1'b0;
    end else begin
      tout_q      <= tout_d;
      pend_q      <= pend_d;
      lcd_cmd_q   <= lcd_cmd_d;
      lcd_data_q  <= lcd_data_d;
      rot_ctl_q   <= rot_ctl_d;
      tout_err_q  <= tout_err_d;
      ovf_err_q   <= ovf_err_d;
      cand_q      <= rot_raw;
      run_q       <= run_d;
      rot_count_q <= rot_count_d;
      rot_upd_q   <= rot_upd_d;
    end
  end

  assign cmd_full      = fifo_full;
  assign lcd_idle      = fifo_empty && (state_q == ST_IDLE);
  assign timeout_err   = tout_err_q;
  assign overflow_err  = ovf_err_q;
  assign lcd_cmd       = lcd_cmd_q;
  assign lcd_data      = lcd_data_q;
  assign rotary_ctl    = rot_ctl_q;
  assign rot_count     = rot_count_q;
  assign rot_count_upd = rot_upd_q;

endmodule

// File: tb/tb_pmod_host_if.sv
// Self-checking bench for pmod_host_if: directed table, handshake sequences, randomized rotary traffic.
module tb_pmod_host_if;

  localparam int unsigned TOUT = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [6:0]  cmd_code = '0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_full, lcd_idle;
  logic        err_clr = 1'b0;
  logic        timeout_err, overflow_err;
  logic        rot_ctl_wr = 1'b0;
  logic [7:0]  rot_ctl_din = '0;
  logic [7:0]  lcd_status;
  logic [7:0]  rotary_status = '0;
  logic [7:0]  rotary_count_lo = '0;
  logic [7:0]  rotary_count_hi = '0;
  logic [7:0]  lcd_cmd, lcd_data, rotary_ctl;
  logic [15:0] rot_count;
  logic        rot_count_upd;

  always #5 clk = ~clk;

  pmod_host_if #(
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(TOUT),
    .TOUT_W(20)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_wr(cmd_wr), .cmd_code(cmd_code), .cmd_data(cmd_data),
    .cmd_full(cmd_full), .lcd_idle(lcd_idle),
    .err_clr(err_clr), .timeout_err(timeout_err), .overflow_err(overflow_err),
    .rot_ctl_wr(rot_ctl_wr), .rot_ctl_din(rot_ctl_din),
    .lcd_status(lcd_status), .rotary_status(rotary_status),
    .rotary_count_lo(rotary_count_lo), .rotary_count_hi(rotary_count_hi),
    .lcd_cmd(lcd_cmd), .lcd_data(lcd_data), .rotary_ctl(rotary_ctl),
    .rot_count(rot_count), .rot_count_upd(rot_count_upd)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Picoblaze stand-in. Mode 0: hold man_status. Mode 1: ack GO after ack_dly cycles,
  // clear busy ack done_dly cycles after GO drops. Mode 2: busy never asserted.
  int          resp_mode = 0;
  logic [7:0]  man_status = 8'h80;
  int          ack_dly = 2;
  int          done_dly = 3;

  initial begin : responder
    int cnt;
    cnt = 0;
    lcd_status = 8'h80;
    forever begin
      @(posedge clk);
      #2;
      case (resp_mode)
        0: lcd_status = man_status;
        1: begin
          if (!lcd_status[7]) begin
            if (lcd_cmd[7] === 1'b1) begin
              if (cnt >= ack_dly) begin lcd_status = 8'h80; cnt = 0; end
              else cnt++;
            end else cnt = 0;
          end else begin
            if (lcd_cmd[7] !== 1'b1) begin
              if (cnt >= done_dly) begin lcd_status = 8'h00; cnt = 0; end
              else cnt++;
            end else cnt = 0;
          end
        end
        default: lcd_status = 8'h00;
      endcase
    end
  end

  // Records {code, data} each time GO rises.
  logic [14:0] obs[$];
  initial begin : monitor
    logic prev_go;
    prev_go = 1'b0;
    forever begin
      @(negedge clk);
      if (lcd_cmd[7] === 1'b1 && !prev_go) obs.push_back({lcd_cmd[6:0], lcd_data});
      prev_go = (lcd_cmd[7] === 1'b1);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic [6:0] code, input logic [7:0] data);
    cmd_wr = 1'b1; cmd_code = code; cmd_data = data;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (lcd_idle === 1'b1 && lcd_status[7] === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic check_obs(input string name, input int base, input logic [14:0] exp[$]);
    chk({name, "_count"}, 32'(obs.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < obs.size()) chk({name, "_entry"}, 32'(obs[base + i]), 32'(exp[i]));
      else chk({name, "_missing"}, 32'h7fff_ffff, 32'(exp[i]));
    end
  endtask

  // Rotary reference: the last three samples, judged as a window.
  logic [15:0] hv[$];
  logic        hb[$];
  logic [15:0] exp_count;
  int          n_upd;

  task automatic rot_step(input logic [7:0] hi, input logic [7:0] lo, input logic b,
                          input logic [7:0] other);
    logic exp_upd;
    logic all_ok;
    rotary_count_hi = hi;
    rotary_count_lo = lo;
    rotary_status   = {other[7:1], b};
    tick();
    hv.push_back({hi, lo});
    hb.push_back(b);
    if (hv.size() > 3) begin void'(hv.pop_front()); void'(hb.pop_front()); end
    all_ok = (hv.size() == 3);
    foreach (hv[k]) if (hb[k] || hv[k] != {hi, lo}) all_ok = 1'b0;
    exp_upd = all_ok && ({hi, lo} != exp_count);
    if (exp_upd) exp_count = {hi, lo};
    chk("rot_count", 32'(rot_count), 32'(exp_count));
    chk("rot_count_upd", 32'(rot_count_upd), 32'(exp_upd));
    if (rot_count_upd === 1'b1) n_upd++;
  endtask

  typedef struct {
    logic       wr;
    logic [6:0] code;
    logic [7:0] data;
    logic       clr;
    logic       rcw;
    logic [7:0] rcd;
    logic       e_full;
    logic       e_ovf;
    logic [7:0] e_rc;
  } vec_t;

  vec_t tbl[11];

  initial begin : main
    logic [14:0] expq[$];
    int          base;
    int          n;
    logic        seen;
    logic [15:0] v;

    tbl[0]  = '{1'b1, 7'h01, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 7'h02, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 7'h13, 8'h43, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 7'h7F, 8'h44, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 7'h55, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    tbl[5]  = '{1'b0, 7'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 7'h66, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 7'h00, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 8'hC3};
    tbl[8]  = '{1'b0, 7'h00, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h3C};
    tbl[9]  = '{1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C};
    tbl[10] = '{1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C};

    // Reset with Picoblaze reporting busy.
    repeat (3) tick();
    chk("rst_lcd_cmd", 32'(lcd_cmd), 32'h00);
    chk("rst_lcd_data", 32'(lcd_data), 32'h00);
    chk("rst_rotary_ctl", 32'(rotary_ctl), 32'h00);
    chk("rst_rot_count", 32'(rot_count), 32'h0000);
    chk("rst_rot_upd", 32'(rot_count_upd), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_overflow_err", 32'(overflow_err), 32'd0);
    chk("rst_cmd_full", 32'(cmd_full), 32'd0);
    chk("rst_lcd_idle", 32'(lcd_idle), 32'd0);
    reset_n = 1'b1;

    // FIFO fill, overflow, err_clr priority and rotary_ctl, all while held in INIT.
    base = obs.size();
    for (int i = 0; i < 11; i++) begin
      cmd_wr = tbl[i].wr; cmd_code = tbl[i].code; cmd_data = tbl[i].data;
      err_clr = tbl[i].clr; rot_ctl_wr = tbl[i].rcw; rot_ctl_din = tbl[i].rcd;
      tick();
      cmd_wr = 1'b0; err_clr = 1'b0; rot_ctl_wr = 1'b0;
      chk("tbl_cmd_full", 32'(cmd_full), 32'(tbl[i].e_full));
      chk("tbl_overflow_err", 32'(overflow_err), 32'(tbl[i].e_ovf));
      chk("tbl_rotary_ctl", 32'(rotary_ctl), 32'(tbl[i].e_rc));
      chk("tbl_no_go_in_init", 32'(lcd_cmd), 32'h00);
      chk("tbl_lcd_idle", 32'(lcd_idle), 32'd0);
    end

    // Release busy; the four accepted commands drain in order.
    ack_dly = 2; done_dly = 3; resp_mode = 1;
    wait_idle("drain_idle", 400);
    expq = '{15'({7'h01, 8'h41}), 15'({7'h02, 8'h42}), 15'({7'h13, 8'h43}), 15'({7'h7F, 8'h44})};
    check_obs("drain", base, expq);
    chk("drain_lcd_cmd", 32'(lcd_cmd), 32'h7F);
    chk("drain_lcd_data", 32'(lcd_data), 32'h44);
    chk("drain_timeout_err", 32'(timeout_err), 32'd0);

    // Push-to-GO latency and rotary_ctl write mid-handshake.
    base = obs.size();
    push_cmd(7'h2A, 8'h99);
    chk("lat_n0_go", 32'(lcd_cmd[7]), 32'd0);
    tick();
    chk("lat_n1_go", 32'(lcd_cmd[7]), 32'd0);
    tick();
    chk("lat_n2_lcd_cmd", 32'(lcd_cmd), 32'hAA);
    chk("lat_n2_lcd_data", 32'(lcd_data), 32'h99);
    rot_ctl_wr = 1'b1; rot_ctl_din = 8'h5A;
    tick();
    rot_ctl_wr = 1'b0;
    chk("rotctl_mid_hs", 32'(rotary_ctl), 32'h5A);
    wait_idle("lat_idle", 100);
    expq = '{15'({7'h2A, 8'h99})};
    check_obs("lat", base, expq);
    chk("lat_data_held", 32'(lcd_data), 32'h99);
    chk("rotctl_held", 32'(rotary_ctl), 32'h5A);

    // Random bursts of three commands with random responder delays.
    for (int r = 0; r < 3; r++) begin
      ack_dly = int'($urandom_range(0, 4));
      done_dly = int'($urandom_range(0, 4));
      base = obs.size();
      expq.delete();
      for (int k = 0; k < 3; k++) begin
        logic [6:0] c;
        logic [7:0] d;
        c = 7'($urandom);
        d = 8'($urandom);
        expq.push_back({c, d});
        push_cmd(c, d);
      end
      wait_idle("rand_idle", 300);
      check_obs("rand_burst", base, expq);
    end
    chk("rand_overflow_err", 32'(overflow_err), 32'd0);

    // Timeout: responder never acknowledges; the next command still issues.
    resp_mode = 2;
    base = obs.size();
    push_cmd(7'h11, 8'hA1);
    push_cmd(7'h22, 8'hB2);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (lcd_cmd[7] === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    chk("tout_go_seen", 32'(seen), 32'd1);
    n = 0;
    while (lcd_cmd[7] === 1'b1 && n < 200) begin tick(); n++; end
    resp_mode = 1;
    chk("tout_go_dropped_by_50", 32'(n >= 49 && n <= TOUT), 32'd1);
    if (!(n >= 49 && n <= TOUT)) $display("FAIL tout_cycles: got %0d, expected 49..%0d", n, TOUT);
    chk("tout_err_set", 32'(timeout_err), 32'd1);
    chk("tout_lcd_cmd", 32'(lcd_cmd), 32'h11);
    wait_idle("tout_idle", 200);
    expq = '{15'({7'h11, 8'hA1}), 15'({7'h22, 8'hB2})};
    check_obs("tout", base, expq);
    chk("tout_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tout_err_cleared", 32'(timeout_err), 32'd0);

    // Rotary snapshot. Inputs have been held at zero since reset.
    hv = '{16'h0, 16'h0, 16'h0};
    hb = '{1'b0, 1'b0, 1'b0};
    exp_count = 16'h0000;
    for (int i = 0; i < 5; i++) rot_step(8'h00, 8'hFF, 1'b0, 8'h00);
    n_upd = 0;
    seen = 1'b0;
    rot_step(8'h00, 8'hFF, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      rot_step(8'h00, 8'h00, 1'b1, 8'h00);
      if (rot_count == 16'h0000 || rot_count == 16'h01FF) seen = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      rot_step(8'h01, 8'h00, 1'b1, 8'h00);
      if (rot_count == 16'h0000 || rot_count == 16'h01FF) seen = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      rot_step(8'h01, 8'h00, 1'b0, 8'h00);
      if (rot_count == 16'h0000 || rot_count == 16'h01FF) seen = 1'b1;
    end
    chk("rot_no_torn_value", 32'(seen), 32'd0);
    chk("rot_single_pulse", 32'(n_upd), 32'd1);
    chk("rot_final_0100", 32'(rot_count), 32'h0100);

    v = 16'h0100;
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 2) v = 16'($urandom);
      else if (r == 2) v = v + 16'd1;
      else if (r == 3) v = 16'hFFFF;
      rot_step(v[15:8], v[7:0], ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    for (int i = 0; i < 4; i++) rot_step(8'hFF, 8'hFF, 1'b0, 8'h00);
    n_upd = 0;
    for (int i = 0; i < 4; i++) rot_step(8'h00, 8'h00, 1'b0, 8'hFE);
    chk("rot_wrap_value", 32'(rot_count), 32'h0000);
    chk("rot_wrap_pulses", 32'(n_upd), 32'd1);
    for (int i = 0; i < 4; i++) rot_step(8'h12, 8'h34, 1'b0, 8'h00);

    // Reset during WAIT_ACK with a full FIFO and overflow flagged.
    resp_mode = 0; man_status = 8'h00;
    push_cmd(7'h31, 8'hC1);
    push_cmd(7'h32, 8'hC2);
    push_cmd(7'h33, 8'hC3);
    push_cmd(7'h34, 8'hC4);
    push_cmd(7'h35, 8'hC5);
    push_cmd(7'h36, 8'hC6);
    chk("prerst_go", 32'(lcd_cmd), 32'hB1);
    chk("prerst_overflow", 32'(overflow_err), 32'd1);
    chk("prerst_rot_count", 32'(rot_count), 32'h1234);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_lcd_cmd", 32'(lcd_cmd), 32'h00);
    chk("midrst_lcd_data", 32'(lcd_data), 32'h00);
    chk("midrst_rotary_ctl", 32'(rotary_ctl), 32'h00);
    chk("midrst_rot_count", 32'(rot_count), 32'h0000);
    chk("midrst_rot_upd", 32'(rot_count_upd), 32'd0);
    chk("midrst_overflow", 32'(overflow_err), 32'd0);
    chk("midrst_timeout", 32'(timeout_err), 32'd0);
    chk("midrst_cmd_full", 32'(cmd_full), 32'd0);
    chk("midrst_in_init", 32'(lcd_idle), 32'd0);
    tick();
    chk("postrst_idle_empty", 32'(lcd_idle), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (lcd_cmd[7] !== 1'b0) seen = 1'b1;
    end
    chk("postrst_no_stale_go", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
